// File: rtl/lcd_rd_pkg.sv
// Shared constants for the HD44780 read engine: op codes, FSM state codes and
// default 50 MHz bus timing.
package lcd_rd_pkg;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_DATA   = 2'b01;
  localparam logic [1:0] OP_POLL   = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WAIT_GNT = 3'd1;
  localparam state_t ST_SETUP    = 3'd2;
  localparam state_t ST_EN_HI    = 3'd3;
  localparam state_t ST_EN_LO    = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  localparam int T_AS_DEF     = 3;
  localparam int T_PW_DEF     = 13;
  localparam int T_REC_DEF    = 13;
  localparam int POLL_MAX_DEF = 1000;
  localparam int BF_BIT       = 7;

  // Reserved op 11 (and op 10 when polling is not built) degrade to a status read.
  function automatic logic [1:0] map_op(input logic [1:0] op, input logic poll_en);
    case (op)
      OP_DATA: map_op = OP_DATA;
      OP_POLL: map_op = poll_en ? OP_POLL : OP_STATUS;
      default: map_op = OP_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/lcd_rd_timer.sv
// Loadable 8-bit down-counter; done_o marks the last cycle of a loaded phase.
module lcd_rd_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd1);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle engine (busy flag / DDRAM-CGRAM data) behind a bus request/grant.
// Build option: define LCD_RD_POLL_EN to make op 10 poll until the busy flag clears.
module lcd_bus_reader
  import lcd_rd_pkg::*;
#(
  parameter int T_AS     = T_AS_DEF,
  parameter int T_PW     = T_PW_DEF,
  parameter int T_REC    = T_REC_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF
) (
  input  logic       iCLK,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_bf,
  output logic       rsp_err,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] lcd_data_in
);

  if (T_AS < 1 || T_AS > 255 || T_PW < 1 || T_PW > 255 || T_REC < 1 || T_REC > 255 ||
      POLL_MAX < 1 || POLL_MAX > 65535) begin : g_param_err
    $error("lcd_bus_reader: parameter out of range");
  end

`ifdef LCD_RD_POLL_EN
  localparam logic POLL_EN = 1'b1;
`else
  localparam logic POLL_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_bf_q, rsp_bf_d, rsp_err_q, rsp_err_d;
  logic       ready_q, rsp_valid_q, bus_req_q, rs_q, rw_q, en_q;
  logic       tmr_load_s, tmr_done_s;
  logic [7:0] tmr_val_s;
  logic       in_xfer_s, gnt_lost_s, retry_s, timeout_s, xfer_next_s;

  assign in_xfer_s  = (state_q == ST_SETUP) || (state_q == ST_EN_HI) || (state_q == ST_EN_LO);
  assign gnt_lost_s = in_xfer_s && !bus_gnt;

  lcd_rd_timer u_timer (
    .clk_i      (iCLK),
    .rst_i      (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .done_o     (tmr_done_s)
  );

`ifdef LCD_RD_POLL_EN
  localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);
  logic [15:0] poll_cnt_q, poll_cnt_d;

  // The attempt count starts at 1 for the first read; a busy read retries until the limit.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    retry_s    = 1'b0;
    timeout_s  = 1'b0;
    if (state_q == ST_IDLE) begin
      poll_cnt_d = 16'd1;
    end else if ((state_q == ST_EN_LO) && tmr_done_s && !gnt_lost_s &&
                 (op_q == OP_POLL) && data_q[BF_BIT]) begin
      if (poll_cnt_q < POLL_MAX_W) begin
        retry_s    = 1'b1;
        poll_cnt_d = poll_cnt_q + 16'd1;
      end else begin
        timeout_s  = 1'b1;
      end
    end else begin
      poll_cnt_d = poll_cnt_q;
    end
  end

  // Poll attempt counter.
  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      poll_cnt_q <= 16'd0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`else
  assign retry_s   = 1'b0;
  assign timeout_s = 1'b0;
`endif

  // Read-cycle sequencing and response capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_bf_d   = rsp_bf_q;
    rsp_err_d  = rsp_err_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          op_d    = map_op(req_op, POLL_EN);
          state_d = ST_WAIT_GNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_GNT: begin
        if (bus_gnt) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = 8'(T_AS);
          state_d    = ST_SETUP;
        end else begin
          state_d    = ST_WAIT_GNT;
        end
      end
      ST_SETUP, ST_EN_HI, ST_EN_LO: begin
        if (gnt_lost_s) begin
          state_d    = ST_DONE;
          rsp_data_d = 8'h00;
          rsp_bf_d   = 1'b0;
          rsp_err_d  = 1'b1;
        end else if (!tmr_done_s) begin
          state_d    = state_q;
        end else if (state_q == ST_SETUP) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = 8'(T_PW);
          state_d    = ST_EN_HI;
        end else if (state_q == ST_EN_HI) begin
          data_d     = lcd_data_in;
          tmr_load_s = 1'b1;
          tmr_val_s  = 8'(T_REC);
          state_d    = ST_EN_LO;
        end else if (retry_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = 8'(T_AS);
          state_d    = ST_SETUP;
        end else begin
          state_d    = ST_DONE;
          rsp_data_d = data_q;
          rsp_bf_d   = (op_q != OP_DATA) && data_q[BF_BIT];
          rsp_err_d  = timeout_s;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer_next_s = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_EN_LO);

  // State, data and output registers; pin levels follow the next state.
  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      data_q      <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_bf_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      bus_req_q   <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_bf_q    <= rsp_bf_d;
      rsp_err_q   <= rsp_err_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_DONE);
      bus_req_q   <= (state_d == ST_WAIT_GNT) || xfer_next_s;
      rs_q        <= xfer_next_s && op_d[0];
      rw_q        <= xfer_next_s;
      en_q        <= (state_d == ST_EN_HI);
    end
  end

  // Pins are released combinationally the moment the grant disappears.
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_bf    = rsp_bf_q;
  assign rsp_err   = rsp_err_q;
  assign bus_req   = bus_req_q && !gnt_lost_s;
  assign lcd_rs    = rs_q && bus_gnt;
  assign lcd_rw    = rw_q && bus_gnt;
  assign lcd_en    = en_q && bus_gnt;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: status/data reads, grant wait and loss,
// async reset, and (with LCD_RD_POLL_EN) poll retry and timeout.
module tb_lcd_bus_reader;

  logic       clk, rst;
  logic       req_valid, req_ready, rsp_valid, rsp_bf, rsp_err, bus_req, bus_gnt;
  logic [1:0] req_op;
  logic [7:0] rsp_data, lcd_data_in;
  logic       lcd_rs, lcd_rw, lcd_en;
  int         n_total = 0;
  int         n_bad   = 0;

  lcd_bus_reader dut (
    .iCLK(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_bf(rsp_bf), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data_in(lcd_data_in)
  );

`ifdef LCD_RD_POLL_EN
  logic       p_req_valid, p_req_ready, p_rsp_valid, p_rsp_bf, p_rsp_err, p_bus_req;
  logic [7:0] p_rsp_data;
  logic       p_lcd_rs, p_lcd_rw, p_lcd_en;

  lcd_bus_reader #(.POLL_MAX(2)) dut_p2 (
    .iCLK(clk), .rst(rst), .req_valid(p_req_valid), .req_ready(p_req_ready), .req_op(2'b10),
    .rsp_valid(p_rsp_valid), .rsp_data(p_rsp_data), .rsp_bf(p_rsp_bf), .rsp_err(p_rsp_err),
    .bus_req(p_bus_req), .bus_gnt(1'b1), .lcd_rs(p_lcd_rs), .lcd_rw(p_lcd_rw), .lcd_en(p_lcd_en),
    .lcd_data_in(8'hFF)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for ready, then present one request; returns #1 after the accept edge.
  task automatic start_req(input logic [1:0] op);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
  endtask

  task automatic run_txn(input string name, input logic [1:0] op, input logic [31:0] dseq,
                         input int gnt_delay, input int drop_k, input logic exp_rs,
                         input int exp_lat, input int exp_pulses, input logic [7:0] exp_data,
                         input logic exp_bf, input logic exp_err);
    int k, k_rw, k_en, pulses, en_cyc, rs_bad, idx;
    logic prev_en, got;
    lcd_data_in = 8'hFF;
    bus_gnt = (gnt_delay == 0);
    start_req(op);
    k = 0; k_rw = -1; k_en = -1; pulses = 0; en_cyc = 0; rs_bad = 0;
    prev_en = 1'b0; got = 1'b0;
    check_eq({name, "_accept_breq"}, bus_req, 1);
    check_eq({name, "_busy_ready"}, req_ready, 0);
    while (!got && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (gnt_delay > 0 && k == gnt_delay) begin
        check_eq({name, "_wait_pins"}, {bus_req, lcd_rw, lcd_en, rsp_valid}, 4'b1000);
        bus_gnt = 1'b1;
      end
      if (lcd_rw && k_rw < 0) k_rw = k;
      if (lcd_en && !prev_en) begin
        idx = (pulses < 4) ? pulses : 3;
        lcd_data_in = dseq[idx*8 +: 8];
        if (k_en < 0) k_en = k;
        pulses++;
      end
      if (lcd_en) en_cyc++;
      if (lcd_rw && (lcd_rs !== exp_rs)) rs_bad++;
      prev_en = lcd_en;
      if (drop_k > 0 && k == drop_k) begin
        bus_gnt = 1'b0;
        #1;
        check_eq({name, "_drop_pins"}, {lcd_en, lcd_rw, lcd_rs, bus_req, rsp_valid}, 5'b0);
      end
      if (rsp_valid) got = 1'b1;
    end
    check_eq({name, "_rsp_seen"}, got, 1);
    check_eq({name, "_latency"}, k - gnt_delay, exp_lat);
    check_eq({name, "_data"}, rsp_data, exp_data);
    check_eq({name, "_bf"}, rsp_bf, exp_bf);
    check_eq({name, "_err"}, rsp_err, exp_err);
    check_eq({name, "_done_pins"}, {lcd_rw, bus_req}, 2'b00);
    check_eq({name, "_pulses"}, pulses, exp_pulses);
    check_eq({name, "_rs"}, rs_bad, 0);
    if (drop_k == 0) begin
      check_eq({name, "_en_width"}, en_cyc, 13 * exp_pulses);
      check_eq({name, "_rw_to_en"}, k_en - k_rw, 3);
    end
    @(posedge clk); #1;
    check_eq({name, "_rsp_one_cycle"}, rsp_valid, 0);
    check_eq({name, "_ready_after"}, req_ready, 1);
    bus_gnt = 1'b1;
  endtask

  initial begin
    logic seen;
    int   k, pulses;
    logic prev_en;
    rst = 1'b1; bus_gnt = 1'b1; req_valid = 1'b0; req_op = 2'b00; lcd_data_in = 8'h00;
`ifdef LCD_RD_POLL_EN
    p_req_valid = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {req_ready, rsp_valid, rsp_data, rsp_bf, rsp_err, bus_req,
                            lcd_rs, lcd_rw, lcd_en}, 16'h0);
    @(negedge clk) rst = 1'b0;
    #1;
    check_eq("ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    check_eq("ready_first_cycle", req_ready, 1);

    run_txn("status45", 2'b00, 32'h45454545, 0, 0, 1'b0, 30, 1, 8'h45, 1'b0, 1'b0);
    run_txn("data41",   2'b01, 32'h41414141, 0, 0, 1'b1, 30, 1, 8'h41, 1'b0, 1'b0);
    run_txn("statusC5", 2'b00, 32'hC5C5C5C5, 0, 0, 1'b0, 30, 1, 8'hC5, 1'b1, 1'b0);
    run_txn("dataC5",   2'b01, 32'hC5C5C5C5, 0, 0, 1'b1, 30, 1, 8'hC5, 1'b0, 1'b0);
    run_txn("op11",     2'b11, 32'h85858585, 0, 0, 1'b0, 30, 1, 8'h85, 1'b1, 1'b0);
    run_txn("gntwait",  2'b00, 32'h7F7F7F7F, 6, 0, 1'b0, 30, 1, 8'h7F, 1'b0, 1'b0);
`ifdef LCD_RD_POLL_EN
    run_txn("poll",     2'b10, 32'h12808080, 0, 0, 1'b0, 117, 4, 8'h12, 1'b0, 1'b0);
`else
    run_txn("op10",     2'b10, 32'h80808080, 0, 0, 1'b0, 30, 1, 8'h80, 1'b1, 1'b0);
`endif
    run_txn("gntloss",  2'b00, 32'h45454545, 0, 8, 1'b0, 9, 1, 8'h00, 1'b0, 1'b1);

    // Async reset in the middle of EN_HI.
    bus_gnt = 1'b1;
    lcd_data_in = 8'h33;
    start_req(2'b00);
    repeat (8) @(posedge clk);
    #1;
    check_eq("rst_pre_en", {lcd_en, lcd_rw}, 2'b11);
    rst = 1'b1;
    #1;
    check_eq("rst_async_pins", {lcd_en, lcd_rw, bus_req, rsp_valid, req_ready}, 5'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready_after", req_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check_eq("rst_no_rsp", seen, 0);

`ifdef LCD_RD_POLL_EN
    // POLL_MAX=2 with the busy flag stuck high.
    p_req_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("p2_accept", p_bus_req, 1);
    p_req_valid = 1'b0;
    k = 0; pulses = 0; prev_en = 1'b0; seen = 1'b0;
    while (!seen && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (p_lcd_en && !prev_en) pulses++;
      prev_en = p_lcd_en;
      if (p_rsp_valid) seen = 1'b1;
    end
    check_eq("p2_rsp_seen", seen, 1);
    check_eq("p2_latency", k, 59);
    check_eq("p2_pulses", pulses, 2);
    check_eq("p2_err", p_rsp_err, 1);
    check_eq("p2_data", p_rsp_data, 8'hFF);
    check_eq("p2_bf", p_rsp_bf, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
